key_search_controller: RTL and testbench

- Sequences the arcfour key-schedule engine and a downstream decrypt/check engine to brute-force a key range.
- For each candidate key it drives the key, launches arcfour (init + shuffle of S RAM), and waits for completion.
- It then launches the decrypt/check engine and samples its pass/fail verdict.
- It stops on the first valid key, on exhaustion of the range, or on an abort request. It sits between top-level control (switches/LEDs) and the arcfour/decrypt pair.

---
 rtl/key_search_controller.sv | 144 ++++++++++++++
 tb/tb_key_search_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_controller.sv
// Brute-force key search sequencer: per candidate, launches arcfour, waits for it, then launches decrypt/check.
// Latency per candidate = 4 control cycles + arcfour + decrypt time; engines are never interrupted mid-run.
module key_search_controller #(
    parameter int                    RAM_WIDTH  = 8,
    parameter int                    KEY_LENGTH = 3,
    parameter int                    KEY_BITS   = 22,
    parameter logic [KEY_BITS-1:0]   KEY_START  = '0,
    parameter int                    KEY_STEP   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             arc_finished,
    input  logic                             dec_done,
    input  logic                             dec_valid,
    output logic                             arc_start,
    output logic                             dec_start,
    output logic [KEY_LENGTH*RAM_WIDTH-1:0]  key,
    output logic                             busy,
    output logic                             found,
    output logic                             exhausted,
    output logic [KEY_LENGTH*RAM_WIDTH-1:0]  found_key,
    output logic [KEY_BITS:0]                attempts,
    output logic [2:0]                       state_tap
);

    localparam int                KW       = KEY_LENGTH * RAM_WIDTH;
    localparam logic [KEY_BITS:0] STEP_EXT = (KEY_BITS+1)'(KEY_STEP);
    localparam logic [KEY_BITS:0] ONE_EXT  = (KEY_BITS+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARC_START = 3'd1,
        S_ARC_CLEAR = 3'd2,
        S_ARC_WAIT  = 3'd3,
        S_DEC_START = 3'd4,
        S_DEC_WAIT  = 3'd5,
        S_NEXT      = 3'd6
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [KEY_BITS-1:0] key_cnt;
    logic                abort_pending;

    logic                accept;
    logic                inc_attempt;
    logic                hit;
    logic                advance;
    logic                exhaust;
    logic [KEY_BITS:0]   nxt_sum;

    assign nxt_sum = {1'b0, key_cnt} + STEP_EXT;

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        inc_attempt = 1'b0;
        hit         = 1'b0;
        advance     = 1'b0;
        exhaust     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_ARC_START;
                end
            end
            S_ARC_START: state_nxt = S_ARC_CLEAR;
            // arc_finished is still high from the previous run; see it fall first
            S_ARC_CLEAR: begin
                if (!arc_finished) state_nxt = S_ARC_WAIT;
            end
            S_ARC_WAIT: begin
                if (arc_finished) state_nxt = abort_pending ? S_IDLE : S_DEC_START;
            end
            S_DEC_START: state_nxt = S_DEC_WAIT;
            S_DEC_WAIT: begin
                if (dec_done) begin
                    inc_attempt = 1'b1;
                    if (dec_valid) begin
                        hit       = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (abort_pending) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (nxt_sum[KEY_BITS]) begin
                    exhaust   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    advance   = 1'b1;
                    state_nxt = S_ARC_START;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            key_cnt       <= '0;
            busy          <= 1'b0;
            found         <= 1'b0;
            exhausted     <= 1'b0;
            found_key     <= '0;
            attempts      <= '0;
            abort_pending <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);

            if (accept) begin
                key_cnt       <= KEY_START;
                attempts      <= '0;
                found         <= 1'b0;
                exhausted     <= 1'b0;
                found_key     <= '0;
                abort_pending <= 1'b0;
            end else begin
                if (abort && state != S_IDLE) abort_pending <= 1'b1;
                if (advance)     key_cnt   <= nxt_sum[KEY_BITS-1:0];
                if (inc_attempt) attempts  <= attempts + ONE_EXT;
                if (exhaust)     exhausted <= 1'b1;
                if (hit) begin
                    found     <= 1'b1;
                    found_key <= key;
                end
            end
        end
    end

    assign key       = KW'(key_cnt);
    assign arc_start = (state == S_ARC_START);
    assign dec_start = (state == S_DEC_START);
    assign state_tap = state;

endmodule

// File: tb/tb_key_search_controller.sv
// Directed bench: two controller instances (stride 1 from 0, stride 3 from 1) share behavioural arcfour/decrypt models.
module tb_key_search_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic abort = 1'b0;
    logic arc_fin;
    logic dec_done;
    logic dec_valid;

    logic        a_arc_start, a_dec_start, a_busy, a_found, a_exh;
    logic [23:0] a_key, a_fkey;
    logic [4:0]  a_att;
    logic [2:0]  a_st;
    logic        b_arc_start, b_dec_start, b_busy, b_found, b_exh;
    logic [23:0] b_key, b_fkey;
    logic [4:0]  b_att;
    logic [2:0]  b_st;

    bit          sel = 1'b0;
    logic        m_arc_start, m_dec_start, m_busy, m_found, m_exh;
    logic [23:0] m_key, m_fkey;
    logic [4:0]  m_att;
    logic [2:0]  m_st;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    key_search_controller #(
        .RAM_WIDTH(8), .KEY_LENGTH(3), .KEY_BITS(4), .KEY_START(4'd0), .KEY_STEP(1)
    ) dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .abort(abort),
        .arc_finished(arc_fin), .dec_done(dec_done), .dec_valid(dec_valid),
        .arc_start(a_arc_start), .dec_start(a_dec_start), .key(a_key), .busy(a_busy),
        .found(a_found), .exhausted(a_exh), .found_key(a_fkey), .attempts(a_att),
        .state_tap(a_st)
    );

    key_search_controller #(
        .RAM_WIDTH(8), .KEY_LENGTH(3), .KEY_BITS(4), .KEY_START(4'd1), .KEY_STEP(3)
    ) dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .abort(abort),
        .arc_finished(arc_fin), .dec_done(dec_done), .dec_valid(dec_valid),
        .arc_start(b_arc_start), .dec_start(b_dec_start), .key(b_key), .busy(b_busy),
        .found(b_found), .exhausted(b_exh), .found_key(b_fkey), .attempts(b_att),
        .state_tap(b_st)
    );

    assign m_arc_start = sel ? b_arc_start : a_arc_start;
    assign m_dec_start = sel ? b_dec_start : a_dec_start;
    assign m_busy      = sel ? b_busy      : a_busy;
    assign m_found     = sel ? b_found     : a_found;
    assign m_exh       = sel ? b_exh       : a_exh;
    assign m_key       = sel ? b_key       : a_key;
    assign m_fkey      = sel ? b_fkey      : a_fkey;
    assign m_att       = sel ? b_att       : a_att;
    assign m_st        = sel ? b_st        : a_st;

    // arcfour model: optional stale-high hold, then low for arc_lat cycles, then high again
    int stale_hold = 0;
    int arc_lat    = 20;
    int a_hold, a_lat;
    bit a_run, a_dropped;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arc_fin   <= 1'b1;
            a_run     <= 1'b0;
            a_hold    <= 0;
            a_lat     <= 0;
            a_dropped <= 1'b0;
        end else if (!a_run) begin
            if (m_arc_start) begin
                a_run     <= 1'b1;
                a_hold    <= stale_hold;
                a_dropped <= 1'b0;
            end
        end else if (a_hold > 0) begin
            a_hold <= a_hold - 1;
        end else if (!a_dropped) begin
            arc_fin   <= 1'b0;
            a_dropped <= 1'b1;
            a_lat     <= arc_lat;
        end else if (a_lat > 1) begin
            a_lat <= a_lat - 1;
        end else begin
            arc_fin <= 1'b1;
            a_run   <= 1'b0;
        end
    end

    // decrypt model: done pulse 4 cycles after launch, valid only for the chosen key
    bit          valid_en = 1'b0;
    logic [23:0] valid_key = '0;
    int          d_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_done  <= 1'b0;
            dec_valid <= 1'b0;
            d_cnt     <= 0;
        end else begin
            dec_done  <= 1'b0;
            dec_valid <= 1'b0;
            if (m_dec_start) begin
                d_cnt <= 4;
            end else if (d_cnt == 1) begin
                dec_done  <= 1'b1;
                dec_valid <= valid_en && (m_key == valid_key);
                d_cnt     <= 0;
            end else if (d_cnt > 1) begin
                d_cnt <= d_cnt - 1;
            end
        end
    end

    logic [23:0] arc_keys[$];
    int          dec_cnt = 0;
    int          stale_viol = 0;
    bit          seen_low = 1'b0;
    always @(negedge clk) begin
        if (m_arc_start) begin
            arc_keys.push_back(m_key);
            seen_low <= 1'b0;
        end else if (!arc_fin) begin
            seen_low <= 1'b1;
        end
        if (m_dec_start) begin
            dec_cnt <= dec_cnt + 1;
            if (!seen_low || !arc_fin) stale_viol <= stale_viol + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input bit use_b);
        @(posedge clk);
        #1;
        arc_keys.delete();
        dec_cnt = 0;
        @(negedge clk);
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {31'd0, m_busy}, 32'd0);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input logic [23:0] k, input int budget);
        int n = 0;
        while (!(m_st == st && m_key == k) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {31'd0, (m_st == st && m_key == k)}, 32'd1);
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_busy",  {31'd0, a_busy}, 0);
        check_val("rst_key",   a_key, 0);
        check_val("rst_state", a_st, 0);
        check_val("rst_arc",   {31'd0, a_arc_start}, 0);
        check_val("rst_flags", {a_found, a_exh, b_found, b_exh}, 0);
        check_val("rst_att",   a_att, 0);
        rst_n = 1'b1;

        // valid key at 5
        valid_en = 1'b1; valid_key = 24'd5;
        start_run(1'b0);
        wait_idle("t1_idle", 3000);
        check_val("t1_arc_cnt", arc_keys.size(), 6);
        for (int i = 0; i < arc_keys.size(); i++) check_val("t1_key_seq", arc_keys[i], i);
        check_val("t1_found", {31'd0, m_found}, 1);
        check_val("t1_fkey",  m_fkey, 5);
        check_val("t1_att",   m_att, 6);
        check_val("t1_exh",   {31'd0, m_exh}, 0);

        // exhaustion of 0..15
        valid_en = 1'b0;
        start_run(1'b0);
        wait_idle("t2_idle", 6000);
        check_val("t2_arc_cnt", arc_keys.size(), 16);
        for (int i = 0; i < arc_keys.size(); i++) check_val("t2_key_seq", arc_keys[i], i);
        check_val("t2_exh",   {31'd0, m_exh}, 1);
        check_val("t2_att",   m_att, 16);
        check_val("t2_found", {31'd0, m_found}, 0);
        check_val("t2_fkey",  m_fkey, 0);
        repeat (50) @(negedge clk);
        check_val("t2_no_17th", arc_keys.size(), 16);

        // stale arc_finished held high after launch
        stale_hold = 3; valid_en = 1'b1; valid_key = 24'd2;
        start_run(1'b0);
        wait_idle("t3_idle", 3000);
        check_val("t3_stale_viol", stale_viol, 0);
        check_val("t3_found", {31'd0, m_found}, 1);
        check_val("t3_fkey",  m_fkey, 2);
        check_val("t3_att",   m_att, 3);
        check_val("t3_dec_cnt", dec_cnt, 3);
        stale_hold = 0;

        // abort during ARC_WAIT of key 2
        valid_en = 1'b0;
        start_run(1'b0);
        wait_state("t4_reach", 3'd3, 24'd2, 2000);
        pulse_abort();
        wait_idle("t4_idle", 2000);
        check_val("t4_att",     m_att, 2);
        check_val("t4_dec_cnt", dec_cnt, 2);
        check_val("t4_arc_cnt", arc_keys.size(), 3);
        check_val("t4_flags",   {m_found, m_exh}, 0);
        check_val("t4_arc_fin", {31'd0, arc_fin}, 1);

        // abort during DEC_WAIT of the valid key: found wins
        valid_en = 1'b1; valid_key = 24'd1;
        start_run(1'b0);
        wait_state("t4b_reach", 3'd5, 24'd1, 2000);
        pulse_abort();
        wait_idle("t4b_idle", 2000);
        check_val("t4b_found", {31'd0, m_found}, 1);
        check_val("t4b_fkey",  m_fkey, 1);
        check_val("t4b_att",   m_att, 2);
        check_val("t4b_exh",   {31'd0, m_exh}, 0);

        // stride 3 from 1, plus a start while busy
        sel = 1'b1; valid_en = 1'b0;
        start_run(1'b1);
        repeat (10) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_idle("t5_idle", 3000);
        check_val("t5_arc_cnt", arc_keys.size(), 5);
        for (int i = 0; i < arc_keys.size(); i++) check_val("t5_key_seq", arc_keys[i], 1 + 3 * i);
        check_val("t5_exh",   {31'd0, m_exh}, 1);
        check_val("t5_att",   m_att, 5);
        check_val("t5_found", {31'd0, m_found}, 0);
        sel = 1'b0;

        // asynchronous reset during DEC_WAIT
        start_run(1'b0);
        wait_state("t6_reach", 3'd5, 24'd1, 2000);
        rst_n = 1'b0;
        #1;
        check_val("t6_busy",  {31'd0, a_busy}, 0);
        check_val("t6_key",   a_key, 0);
        check_val("t6_state", a_st, 0);
        check_val("t6_att",   a_att, 0);
        check_val("t6_flags", {a_found, a_exh, a_arc_start, a_dec_start}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_en = 1'b1; valid_key = 24'd0;
        start_run(1'b0);
        wait_idle("t6_idle", 2000);
        check_val("t6_arc_cnt", arc_keys.size(), 1);
        check_val("t6_first_key", (arc_keys.size() > 0) ? arc_keys[0] : 24'hFFFFFF, 0);
        check_val("t6_found", {31'd0, a_found}, 1);
        check_val("t6_att2",  a_att, 1);

        check_val("stale_viol_total", stale_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
